icache_direct: RTL and testbench
================================

# icache_direct

Direct-mapped, read-only instruction cache between the CPU core's instruction port (`inst_read`/`inst_addr`/`inst_resp`/`inst_rdata`) and a 64-bit burst physical-memory port. It serves 32-bit instruction words from 32-byte lines. On a miss it fetches the whole line as a four-beat burst, fills the line, then answers the pending request. The block sits directly downstream of the core's fetch stage and upstream of the memory arbiter.

## Interface
Parameters:
- `NUM_SETS`, default 16. Number of lines; must be a power of two, at least 2. Index width `IDX_W = $clog2(NUM_SETS)`. Tag width `TAG_W = 27 - IDX_W`.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low; reset is applied when `rst == 0` at a rising edge.
- `inst_read` in 1: fetch request; held high with `inst_addr` stable until `inst_resp`.
- `inst_addr` in 32: byte address; bits [1:0] are ignored.
- `inst_resp` out 1: one-cycle pulse; `inst_rdata` is valid in this cycle.
- `inst_rdata` out 32: returned instruction word.
- `pmem_read` out 1: line-fill burst request.
- `pmem_address` out 32: line-aligned fill address, {tag, index, 5'b0}.
- `pmem_rdata` in 64: burst beat data.
- `pmem_resp` in 1: one pulse per valid beat; four pulses per burst.
- `hit_count`, `miss_count` out 32 each: present only under `ICACHE_PERF_EN`.

## Operation
- Address split: tag = `addr[31:5+IDX_W]`, index = `addr[4+IDX_W:5]`, beat = `addr[4:3]`, word-in-beat = `addr[2]`.
- Beat k holds line bytes 8k..8k+7. `pmem_rdata[31:0]` is the lower-address word.
- Storage per set: valid bit, tag, and 256-bit data line. All valid bits clear on reset.
- The FSM has three states: IDLE, LOOKUP, FETCH. Reset state is IDLE.
- IDLE: when `inst_read == 1`, latch `inst_addr` into `addr_q` and go to LOOKUP. `pmem_resp` is ignored in this state.
- LOOKUP, hit (valid and tag match at `addr_q` index): assert `inst_resp`, drive the selected word on `inst_rdata`, go to IDLE.
- LOOKUP, miss: go to FETCH, clear the 2-bit beat counter.
- FETCH: drive `pmem_read = 1` and `pmem_address` from `addr_q`, both stable for the whole burst.
  - Each `pmem_resp` writes `pmem_rdata` into the line buffer slot selected by the beat counter, then increments the counter.
  - On the beat received with counter == 3, write the line buffer into the set, set valid, write the tag, then go to LOOKUP.
  - The counter wraps to 0.
  - The re-lookup then hits.
- A fill replaces the resident line unconditionally. There is no dirty state and no writeback.
- Outputs are driven as follows:
  - `inst_rdata` is 0 whenever `inst_resp == 0`.
  - `pmem_address` is 0 outside FETCH.
- Reset during FETCH:
  - Drop `pmem_read` in the next cycle.
  - Discard partial beats and clear all valid bits.
  - Ignore stray `pmem_resp` pulses afterward.
- A change of `inst_addr` while a request is outstanding is a protocol violation. The latched `addr_q` governs.

## Timing
- Reset values: `inst_resp = 0`, `inst_rdata = 0`, `pmem_read = 0`, `pmem_address = 0`, counters = 0.
- Hit latency: `inst_read` sampled at edge N; `inst_resp` high during cycle N+1. One request completes per two cycles at best.
- Miss latency: `pmem_read` rises in cycle N+2.
  - If the final beat arrives at edge M, `inst_resp` is high during cycle M+1.
  - `pmem_read` is low in cycle M+1.
- `pmem_read` is high during beats. Beats may be non-consecutive; the block waits indefinitely.

## Configuration
- `ICACHE_PERF_EN` defined: the block has `hit_count` and `miss_count` ports.
  - `hit_count` increments on each LOOKUP→IDLE with `inst_resp` that was not preceded by a fill.
  - `miss_count` increments on each LOOKUP→FETCH.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package `cache_types` holds:
  - the FSM state enum `icache_state_t` (IDLE, LOOKUP, FETCH);
  - `ICACHE_LINE_BYTES = 32`, `ICACHE_BEATS = 4`, `ICACHE_OFFSET_W = 5`;
  - the `rv32i_word` alias from `rv32i_types`.
- One sub-module, `icache_array`, holds valid, tag, and data storage.
  - One combinational read port indexed by set.
  - One synchronous write port: line, tag, and set-valid.
  - Synchronous clear-all of the valid bits.
- FSM, beat counter, and line buffer live in `icache_direct`.

## Test plan
- Cold miss at 0x0000_0044: `pmem_read` with `pmem_address` 0x0000_0040; beats 0x11111111_00000000, 0x33333333_22222222, … → `inst_rdata` = 0x11111111 (beat 0, upper word); one fill.
- Hit after fill: read 0x0000_0058 → `inst_resp` one cycle later with beat 3 low word; no `pmem_read`.
- Conflict: fill 0x0000_0040, then read 0x0000_0240 (same index 2, different tag) → new fill at 0x0000_0240. Re-read of 0x0000_0040 → miss again.
- Beat gaps: insert 3 idle cycles between each `pmem_resp` → `pmem_read` and `pmem_address` stay stable; data is correct.
- Reset after beat 2 of a fill → `pmem_read` low the next cycle. A later read of the same address performs a full 4-beat fill.
- `ICACHE_PERF_EN`: 1 miss followed by 3 hits → `miss_count` = 1, `hit_count` = 3.

Source files
------------

// File: rtl/cache_types_pkg.sv
// ============================================================================
// cache_types : shared instruction-cache types (state enum, line geometry)
// rev 1.0
// ============================================================================
`default_nettype none

package rv32i_types;
   typedef logic [31:0] rv32i_word;
endpackage : rv32i_types

package cache_types;
   typedef rv32i_types::rv32i_word rv32i_word;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      FETCH  = 2'd2
   } icache_state_t;

   localparam int ICACHE_LINE_BYTES = 32;
   localparam int ICACHE_BEATS      = 4;
   localparam int ICACHE_OFFSET_W   = 5;
endpackage : cache_types

`default_nettype wire

// File: rtl/icache_array.sv
// ============================================================================
// icache_array : valid/tag/data storage, async read port, sync write + clear
// rev 1.0
// ============================================================================
`default_nettype none

module icache_array
   import cache_types::*;
#(
   parameter int NUM_SETS = 16,
   parameter int IDX_W    = $clog2(NUM_SETS),
   parameter int TAG_W    = 27 - IDX_W
) (
   input  logic                           clk,
   input  logic                           clr_i,
   input  logic [IDX_W-1:0]               rd_idx_i,
   output logic                           rd_valid_o,
   output logic [TAG_W-1:0]               rd_tag_o,
   output logic [ICACHE_LINE_BYTES*8-1:0] rd_line_o,
   input  logic                           we_i,
   input  logic [IDX_W-1:0]               wr_idx_i,
   input  logic [TAG_W-1:0]               wr_tag_i,
   input  logic [ICACHE_LINE_BYTES*8-1:0] wr_line_i
);

   logic [NUM_SETS-1:0]            valid_q;
   logic [TAG_W-1:0]               tag_q  [NUM_SETS];
   logic [ICACHE_LINE_BYTES*8-1:0] data_q [NUM_SETS];

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_line_o  = data_q[rd_idx_i];

   // Only the valid bits are cleared; stale tag/data behind a clear bit is harmless.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_line_i;
      end
   end

endmodule : icache_array

`default_nettype wire

// File: rtl/icache_direct.sv
// ============================================================================
// icache_direct : direct-mapped read-only I-cache, 32B lines, 4x64b burst fill.
// Optional hit/miss counters under ICACHE_PERF_EN.                    rev 1.0
// ============================================================================
`default_nettype none

module icache_direct
   import cache_types::*;
#(
   parameter int NUM_SETS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_read,
   input  rv32i_word   inst_addr,
   output logic        inst_resp,
   output rv32i_word   inst_rdata,
   output logic        pmem_read,
   output rv32i_word   pmem_address,
   input  logic [63:0] pmem_rdata,
   input  logic        pmem_resp
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int TAG_W  = 27 - IDX_W;
   localparam int LINE_W = ICACHE_LINE_BYTES * 8;
   localparam int BEAT_W = $clog2(ICACHE_BEATS);

   icache_state_t     state_q, state_d;
   logic [31:2]       addr_q, addr_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [63:0]       lbuf_q [ICACHE_BEATS-1];
   logic [63:0]       lbuf_d [ICACHE_BEATS-1];

   logic              fill_we;
   logic              hit;
   logic              arr_valid;
   logic [TAG_W-1:0]  arr_tag;
   logic [LINE_W-1:0] arr_line;
   logic [LINE_W-1:0] fill_line;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic              unused_addr_lsb;

   assign unused_addr_lsb = ^inst_addr[1:0];
   assign idx       = addr_q[ICACHE_OFFSET_W +: IDX_W];
   assign tag       = addr_q[31 -: TAG_W];
   assign hit       = arr_valid && (arr_tag == tag);
   // The final beat goes straight into the array alongside the three buffered ones.
   assign fill_line = {pmem_rdata, lbuf_q[2], lbuf_q[1], lbuf_q[0]};

   icache_array #(
      .NUM_SETS (NUM_SETS)
   ) u_array (
      .clk        (clk),
      .clr_i      (~rst),
      .rd_idx_i   (idx),
      .rd_valid_o (arr_valid),
      .rd_tag_o   (arr_tag),
      .rd_line_o  (arr_line),
      .we_i       (fill_we),
      .wr_idx_i   (idx),
      .wr_tag_i   (tag),
      .wr_line_i  (fill_line)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      beat_d       = beat_q;
      lbuf_d       = lbuf_q;
      fill_we      = 1'b0;
      inst_resp    = 1'b0;
      inst_rdata   = '0;
      pmem_read    = 1'b0;
      pmem_address = '0;
      case (state_q)
         IDLE: begin
            if (inst_read) begin
               addr_d  = inst_addr[31:2];
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               inst_resp  = 1'b1;
               inst_rdata = arr_line[{addr_q[4:2], 5'b0} +: 32];
               state_d    = IDLE;
            end else begin
               beat_d  = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            pmem_read    = 1'b1;
            pmem_address = {addr_q[31:ICACHE_OFFSET_W], {ICACHE_OFFSET_W{1'b0}}};
            if (pmem_resp) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == BEAT_W'(ICACHE_BEATS - 1)) begin
                  fill_we = 1'b1;
                  state_d = LOOKUP;
               end else begin
                  lbuf_d[beat_q] = pmem_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         beat_q  <= beat_d;
      end
      lbuf_q <= lbuf_d;
   end

`ifdef ICACHE_PERF_EN
   logic        filled_q;
   logic [31:0] hit_q;
   logic [31:0] miss_q;

   // filled_q marks the re-lookup after a fill so it is not counted as a hit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         filled_q <= 1'b0;
         hit_q    <= '0;
         miss_q   <= '0;
      end else begin
         if (state_q == IDLE && inst_read) begin
            filled_q <= 1'b0;
         end else if (fill_we) begin
            filled_q <= 1'b1;
         end
         if (state_q == LOOKUP && hit && !filled_q && hit_q != '1) begin
            hit_q <= hit_q + 32'd1;
         end
         if (state_q == LOOKUP && !hit && miss_q != '1) begin
            miss_q <= miss_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`endif

endmodule : icache_direct

`default_nettype wire

// File: tb/tb_icache_direct.sv
// ============================================================================
// tb_icache_direct : directed self-checking bench for icache_direct
// rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_icache_direct;

   logic        clk        = 1'b0;
   logic        rst        = 1'b0;
   logic        inst_read  = 1'b0;
   logic [31:0] inst_addr  = '0;
   logic        inst_resp;
   logic [31:0] inst_rdata;
   logic        pmem_read;
   logic [31:0] pmem_address;
   logic [63:0] pmem_rdata = '0;
   logic        pmem_resp  = 1'b0;
`ifdef ICACHE_PERF_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   icache_direct #(
      .NUM_SETS (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .inst_read    (inst_read),
      .inst_addr    (inst_addr),
      .inst_resp    (inst_resp),
      .inst_rdata   (inst_rdata),
      .pmem_read    (pmem_read),
      .pmem_address (pmem_address),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
`ifdef ICACHE_PERF_EN
      ,
      .hit_count    (hit_count),
      .miss_count   (miss_count)
`endif
   );

   // Memory image: word i of a line is i*0x11111111, xored with the line's upper address bits.
   function automatic logic [31:0] mem_word(input logic [31:0] line, input int i);
      return 32'(32'h1111_1111 * i) ^ {line[31:8], 8'h00};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one fetch, serves any burst with `gap` idle cycles between beats.
   task automatic do_read(input string tag, input logic [31:0] a, input int gap,
                          input bit exp_miss, input logic [31:0] exp_w);
      int          cyc        = 0;
      int          beats      = 0;
      int          wait_n     = 0;
      int          resp_cyc   = -1;
      bit          addr_ok    = 1'b1;
      bit          rdata_ok   = 1'b1;
      logic        pr_at_resp = 1'b1;
      logic [31:0] got        = '0;
      logic [31:0] line       = a & 32'hFFFF_FFE0;
      int          exp_lat    = exp_miss ? 6 + 3 * gap : 1;
      inst_read = 1'b1;
      inst_addr = a;
      while (resp_cyc < 0 && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         pmem_resp = 1'b0;
         if (inst_resp) begin
            resp_cyc   = cyc;
            got        = inst_rdata;
            pr_at_resp = pmem_read;
            inst_read  = 1'b0;
         end else begin
            if (inst_rdata !== 32'h0) rdata_ok = 1'b0;
            if (pmem_read) begin
               if (pmem_address !== line) addr_ok = 1'b0;
               if (wait_n > 0) begin
                  wait_n--;
               end else if (beats < 4) begin
                  pmem_resp  = 1'b1;
                  pmem_rdata = {mem_word(line, 2 * beats + 1), mem_word(line, 2 * beats)};
                  beats++;
                  wait_n = gap;
               end
            end
         end
      end
      inst_read = 1'b0;
      pmem_resp = 1'b0;
      check({tag, " latency"}, resp_cyc, exp_lat);
      check({tag, " word"}, got, exp_w);
      check({tag, " beats"}, beats, exp_miss ? 4 : 0);
      check({tag, " fill addr stable"}, 32'(addr_ok), 32'd1);
      check({tag, " rdata zero when idle"}, 32'(rdata_ok), 32'd1);
      check({tag, " pmem_read low at resp"}, 32'(pr_at_resp), 32'd0);
      @(posedge clk); #1;
      check({tag, " resp single pulse"}, 32'(inst_resp), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset inst_resp", 32'(inst_resp), 32'd0);
      check("reset inst_rdata", inst_rdata, 32'h0);
      check("reset pmem_read", 32'(pmem_read), 32'd0);
      check("reset pmem_address", pmem_address, 32'h0);
`ifdef ICACHE_PERF_EN
      check("reset hit_count", hit_count, 32'd0);
      check("reset miss_count", miss_count, 32'd0);
`endif
      rst = 1'b1;

      do_read("cold miss 0x44", 32'h0000_0044, 0, 1'b1, 32'h1111_1111);
      do_read("hit 0x58", 32'h0000_0058, 0, 1'b0, 32'h6666_6666);
      do_read("conflict 0x240", 32'h0000_0240, 0, 1'b1, 32'h0000_0200);
      do_read("refill 0x40", 32'h0000_0040, 0, 1'b1, 32'h0000_0000);
      do_read("gap miss 0x1A8", 32'h0000_01A8, 3, 1'b1, 32'h2222_2322);
      do_read("gap line hit 0x1BC", 32'h0000_01BC, 0, 1'b0, 32'h7777_7677);

      // Reset after three beats of a fill to line 0x80.
      inst_read = 1'b1;
      inst_addr = 32'h0000_0088;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid-fill pmem_read", 32'(pmem_read), 32'd1);
      check("mid-fill pmem_address", pmem_address, 32'h0000_0080);
      for (int k = 0; k < 3; k++) begin
         pmem_resp  = 1'b1;
         pmem_rdata = {mem_word(32'h80, 2 * k + 1), mem_word(32'h80, 2 * k)};
         @(posedge clk); #1;
      end
      pmem_resp = 1'b0;
      rst       = 1'b0;
      inst_read = 1'b0;
      @(posedge clk); #1;
      check("reset drops pmem_read", 32'(pmem_read), 32'd0);
      check("reset clears pmem_address", pmem_address, 32'h0);
      rst       = 1'b1;
      pmem_resp = 1'b1;
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      check("stray resp no inst_resp", 32'(inst_resp), 32'd0);
      check("stray resp no pmem_read", 32'(pmem_read), 32'd0);

      do_read("post-reset fill 0x88", 32'h0000_0088, 0, 1'b1, 32'h2222_2222);
      do_read("hit 0x8C", 32'h0000_008C, 0, 1'b0, 32'h3333_3333);
      do_read("hit 0x90", 32'h0000_0090, 0, 1'b0, 32'h4444_4444);
      do_read("hit 0x9C", 32'h0000_009C, 0, 1'b0, 32'h7777_7777);
`ifdef ICACHE_PERF_EN
      check("perf miss_count", miss_count, 32'd1);
      check("perf hit_count", hit_count, 32'd3);
`endif
      do_read("valid cleared 0x40", 32'h0000_0040, 0, 1'b1, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_icache_direct

`default_nettype wire
